shift_window_n: RTL and testbench

Parametrised successor to the fixed 4×32 shift-history block. Captures a stream of DATA_W-bit words into a DEPTH-entry shift window with a run-time selectable shift direction (forward or inverse). Tracks fill level through a three-state occupancy FSM and pulses a frame strobe every DEPTH accepted words. Sits between a word producer and downstream logic that consumes the last DEPTH words in parallel.

---
 rtl/shift_window_n.sv | 135 +++++++++++++
 tb/tb_shift_window_n.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_window_n.sv
// shift_window_n
//   DEPTH-entry shift window over a stream of DATA_W-bit words, with a shift
//   direction chosen per accepted word, a three-state occupancy FSM and a
//   frame strobe once every DEPTH accepted words.
//
//   Optional feature macro: SHIFT_WINDOW_PARITY_EN (adds per-slot even parity).
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   set          accept enable; register is shifted in when high
//   register     input word
//   dir          0: new word into Shift[0]; 1: new word into Shift[DEPTH-1]
//   clear        synchronous flush, overrides set
//   Shift        window contents (registered)
//   count        valid entries, saturates at DEPTH
//   full         count == DEPTH (decoded from FSM state)
//   frame_valid  one-cycle pulse after every DEPTH-th accepted word
//   parity       per-slot even parity of Shift (SHIFT_WINDOW_PARITY_EN only)
module shift_window_n #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 set,
  input  logic [DATA_W-1:0]                    register,
  input  logic                                 dir,
  input  logic                                 clear,
  output logic [DEPTH-1:0][DATA_W-1:0]         Shift,
  output logic [$clog2(DEPTH+1)-1:0]           count,
  output logic                                 full,
`ifdef SHIFT_WINDOW_PARITY_EN
  output logic [DEPTH-1:0]                     parity,
`endif
  output logic                                 frame_valid
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PH_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                       state;
  logic [PH_W-1:0]              phase;
  logic [DEPTH-1:0][DATA_W-1:0] shift_nxt;
  logic [CNT_W-1:0]             count_inc;
  logic                         reach_full;
  logic                         phase_wrap;

  // Window contents after an accept in the currently requested direction.
  always_comb begin
    shift_nxt = Shift;
    if (dir) begin
      for (int unsigned i = 0; i < DEPTH-1; i++) begin
        shift_nxt[i] = Shift[i+1];
      end
      shift_nxt[DEPTH-1] = register;
    end else begin
      shift_nxt[0] = register;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        shift_nxt[i] = Shift[i-1];
      end
    end
  end

  always_comb begin
    count_inc  = (count == CNT_W'(DEPTH)) ? count : count + CNT_W'(1);
    reach_full = (count_inc == CNT_W'(DEPTH));
    phase_wrap = (phase == PH_W'(DEPTH-1));
  end

`ifdef SHIFT_WINDOW_PARITY_EN
  logic [DEPTH-1:0] parity_nxt;

  // Derived from the next-state window so parity updates on the same edge.
  always_comb begin
    parity_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      parity_nxt[i] = ^shift_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      parity <= '0;
    end else if (set) begin
      parity <= parity_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      Shift       <= '0;
      count       <= '0;
      phase       <= '0;
      full        <= 1'b0;
      frame_valid <= 1'b0;
      state       <= EMPTY;
    end else if (set) begin
      Shift       <= shift_nxt;
      count       <= count_inc;
      phase       <= phase_wrap ? '0 : phase + PH_W'(1);
      frame_valid <= phase_wrap;
      case (state)
        EMPTY: begin
          state <= reach_full ? FULL : FILL;
          full  <= reach_full;
        end
        FILL: begin
          if (reach_full) begin
            state <= FULL;
            full  <= 1'b1;
          end
        end
        FULL: begin
          state <= FULL;
          full  <= 1'b1;
        end
        default: begin
          state <= EMPTY;
          full  <= 1'b0;
        end
      endcase
    end else begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_window_n.sv
module tb_shift_window_n;

  localparam int DW = 32;
  localparam int DP = 4;

  logic                  clk = 1'b0;
  logic                  reset, set, dir, clear;
  logic [DW-1:0]         register;
  logic [DP-1:0][DW-1:0] Shift;
  logic [2:0]            count;
  logic                  full, frame_valid;
`ifdef SHIFT_WINDOW_PARITY_EN
  logic [DP-1:0]         parity;
`endif

  shift_window_n #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .set(set), .register(register), .dir(dir),
    .clear(clear), .Shift(Shift), .count(count), .full(full),
`ifdef SHIFT_WINDOW_PARITY_EN
    .parity(parity),
`endif
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: window as a queue (index 0 = Shift[0]), accepted-word
  // counter since the last flush, frame strobe from the counter.
  logic [DW-1:0] q[$];
  int            acc;
  logic          m_fv;
  bit            run = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_flush();
    q = '{0, 0, 0, 0};
    acc = 0;
    m_fv = 1'b0;
  endtask

  // Drive one cycle, then advance the model with the same inputs.
  task automatic cyc(input logic r, input logic s, input logic d,
                     input logic c, input logic [DW-1:0] w);
    reset = r; set = s; dir = d; clear = c; register = w;
    @(posedge clk);
    if (!r || c) begin
      model_flush();
    end else if (s) begin
      if (!d) begin
        q.push_front(w);
        q.delete(DP);
      end else begin
        q.push_back(w);
        q.delete(0);
      end
      acc++;
      m_fv = (acc % DP) == 0;
    end else begin
      m_fv = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < DP; i++) begin
        chk($sformatf("shift%0d", i), Shift[i], q[i]);
`ifdef SHIFT_WINDOW_PARITY_EN
        chk($sformatf("parity%0d", i), DW'(parity[i]), DW'(^q[i]));
`endif
      end
      chk("count", DW'(count), DW'((acc < DP) ? acc : DP));
      chk("full", DW'(full), DW'(acc >= DP));
      chk("frame_valid", DW'(frame_valid), DW'(m_fv));
    end
  end

  localparam logic [DW-1:0] W0 = 32'h0C011001, W1 = 32'hC1010001,
                            W2 = 32'hCA010001, W3 = 32'h0A0B0B01;

  initial begin
    model_flush();
    reset = 0; set = 1; dir = 0; clear = 0; register = 32'hDEADBEEF;
    @(negedge clk);
    cyc(0, 1, 0, 0, 32'hDEADBEEF);
    cyc(0, 1, 0, 0, 32'hDEADBEEF);
    run = 1;
    chk("rst_count", DW'(count), 0);
    chk("rst_full", DW'(full), 0);
    chk("rst_fv", DW'(frame_valid), 0);
    chk("rst_shift", Shift[2], 0);

    // Forward fill
    cyc(1, 1, 0, 0, W0);
    cyc(1, 1, 0, 0, W1);
    cyc(1, 1, 0, 0, W2);
    chk("fwd_fv_early", DW'(frame_valid), 0);
    chk("fwd_count3", DW'(count), 3);
    cyc(1, 1, 0, 0, W3);
    chk("fwd_s0", Shift[0], W3);
    chk("fwd_s3", Shift[3], W0);
    chk("fwd_count", DW'(count), 4);
    chk("fwd_full", DW'(full), 1);
    chk("fwd_fv", DW'(frame_valid), 1);

    // Overflow
    cyc(1, 1, 0, 0, 32'h12345678);
    chk("ovf_s0", Shift[0], 32'h12345678);
    chk("ovf_s3", Shift[3], W1);
    chk("ovf_count", DW'(count), 4);
    chk("ovf_fv", DW'(frame_valid), 0);
    cyc(1, 1, 0, 0, 32'h11111111);
    cyc(1, 1, 1, 0, 32'h22222222);
    cyc(1, 1, 0, 0, 32'h33333333);
    chk("frame2_fv", DW'(frame_valid), 1);
    cyc(1, 0, 0, 0, 32'h44444444);
    chk("idle_fv", DW'(frame_valid), 0);
    chk("idle_s0", Shift[0], 32'h33333333);

    // Clear beats set while full
    cyc(1, 1, 0, 1, 32'h55555555);
    chk("clr_s0", Shift[0], 0);
    chk("clr_count", DW'(count), 0);
    chk("clr_full", DW'(full), 0);

    // Gapped accepts
    cyc(1, 1, 0, 0, 32'h00000010);
    chk("gap_c1", DW'(count), 1);
    cyc(1, 0, 0, 0, 32'h00000020);
    chk("gap_c1b", DW'(count), 1);
    cyc(1, 1, 0, 0, 32'h00000030);
    chk("gap_c2", DW'(count), 2);
    cyc(1, 0, 1, 0, 32'h00000040);
    chk("gap_c2b", DW'(count), 2);

    // Inverse fill
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, W0);
    cyc(1, 1, 1, 0, W1);
    cyc(1, 1, 1, 0, W2);
    cyc(1, 1, 1, 0, W3);
    chk("inv_s3", Shift[3], W3);
    chk("inv_s0", Shift[0], W0);
    chk("inv_fv", DW'(frame_valid), 1);

    // Mixed direction does not reorder existing contents
    cyc(1, 1, 0, 0, 32'hAAAA0000);
    chk("mix_s0", Shift[0], 32'hAAAA0000);
    chk("mix_s1", Shift[1], W0);
    chk("mix_s3", Shift[3], W2);

    // Clear mid-frame discards partial frame
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 32'h1);
    cyc(1, 1, 0, 0, 32'h2);
    cyc(1, 1, 0, 1, 32'h3);
    cyc(1, 1, 0, 0, 32'h4);
    cyc(1, 1, 1, 0, 32'h5);
    cyc(1, 1, 0, 0, 32'h6);
    chk("partial_fv", DW'(frame_valid), 0);
    cyc(1, 1, 0, 0, 32'h7);
    chk("fresh_fv", DW'(frame_valid), 1);

    // Reset mid-stream
    cyc(1, 1, 0, 0, 32'h8);
    cyc(0, 1, 0, 0, 32'h9);
    chk("midrst_count", DW'(count), 0);
    chk("midrst_s0", Shift[0], 0);

    // Parity of single-bit and two-bit words
    cyc(1, 1, 0, 0, 32'h00000001);
`ifdef SHIFT_WINDOW_PARITY_EN
    chk("par_w1", DW'(parity[0]), 1);
`endif
    cyc(1, 1, 0, 0, 32'h00000003);
`ifdef SHIFT_WINDOW_PARITY_EN
    chk("par_w3", DW'(parity[0]), 0);
    chk("par_w1_moved", DW'(parity[1]), 1);
`endif
    chk("par_s1", Shift[1], 32'h00000001);

    run = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
